fifo_wptr_sync: RTL
===================

// Module: fifo_wptr_sync
// PURPOSE
//  - Write-side pointer/flag engine of the async FIFO, generalised to any power-of-two depth.
//  - Keeps the binary write pointer and its Gray image, and synchronises the read-domain Gray
//    pointer through a SYNC_STAGES flop chain.
//  - Produces registered full, almost-full, free-space and sticky overflow flags.
//  - Sits in the wclk domain between the write port and the dual-port RAM; it is the mirror of
//    the read-side block.
// PARAMETERS
//  - ADDR_WIDTH   3  RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (MSB = wrap)
//  - SYNC_STAGES  2  flops in the raddr_g synchroniser chain, >=2
//  - AFULL_THRESH 2  wafull asserts when free entries <= AFULL_THRESH, range 1..2**ADDR_WIDTH-1
// PORTS
//  - wclk       in   1             write clock
//  - wrst       in   1             asynchronous active-low reset
//  - winc       in   1             write request
//  - raddr_g    in   ADDR_WIDTH+1  read pointer, Gray coded, from rclk domain (asynchronous)
//  - waddress   out  ADDR_WIDTH    RAM write address for the current cycle
//  - waddr_g    out  ADDR_WIDTH+1  write pointer, Gray coded, registered, to rclk domain
//  - wfull      out  1             FIFO full, registered
//  - wafull     out  1             almost full, registered
//  - wfree      out  ADDR_WIDTH+1  free entries 0..2**ADDR_WIDTH, registered
//  - woverflow  out  1             sticky: a winc arrived while wfull was high
// BEHAVIOUR
//  - Reset (wrst low, asynchronous):
//    - wbin, waddr_g and every sync stage clear to 0.
//    - wfull, wafull and woverflow clear to 0; wfree = 2**ADDR_WIDTH.
//  - Write acceptance: wr_en = winc & ~wfull.
//    - wbin_next = wbin + wr_en, wrapping modulo 2**(ADDR_WIDTH+1).
//    - waddress = wbin[ADDR_WIDTH-1:0]; the RAM writes at this address on the same edge that advances wbin.
//  - Gray output: waddr_g <= bin2gray(wbin_next), updated on the same edge as wbin, so it never lags
//    the binary pointer.
//    - Only one bit of waddr_g changes per increment.
//    - waddr_g comes straight from a flop, with no combinational logic after it.
//  - Synchroniser:
//    - rq[0] <= raddr_g and rq[i] <= rq[i-1].
//    - rbin_s = gray2bin(rq[SYNC_STAGES-1]), combinational.
//  - Flags, all registered from next-state values:
//    - used_next = wbin_next - rbin_s, taken modulo 2**(ADDR_WIDTH+1).
//    - wfull <= (used_next == 2**ADDR_WIDTH).
//    - wfree <= 2**ADDR_WIDTH - used_next.
//    - wafull: see CONFIGURATION.
//  - Latency:
//    - An accepted write is reflected in wfull and wfree on the same edge.
//    - A read-pointer change on raddr_g is reflected SYNC_STAGES+1 wclk edges later.
//  - Full behaviour:
//    - winc while wfull: ignored; wbin, waddress and waddr_g hold; woverflow <= 1.
//    - woverflow is cleared only by reset.
//  - Full detection:
//    - wfull requires the wrap bits to differ and the low bits to be equal.
//    - Depth-apart pointers across the wrap boundary (e.g. wbin=0, rbin_s=8 for ADDR_WIDTH=3) are full.
//  - Flag pessimism: because the read pointer is stale, flags may only err toward full. No under-count of
//    used entries is allowed.
//  - Simultaneous winc and a read-pointer update in the same cycle: both are applied in used_next.
// CONFIGURATION
//  - FIFO_WPTR_AFULL_EN defined: wafull <= (2**ADDR_WIDTH - used_next) <= AFULL_THRESH.
//  - FIFO_WPTR_AFULL_EN undefined: wafull is tied to 0, and the threshold comparator is not built.
// STRUCTURE
//  - Package fifo_pkg:
//    - functions bin2gray(b) = b ^ (b >> 1) and gray2bin, an XOR-prefix loop, both width-generic.
//    - localparam DEPTH = 2**ADDR_WIDTH, and the pointer-width localparam.
//  - One sub-module gray_sync #(WIDTH, SYNC_STAGES): an N-flop synchroniser with asynchronous
//    active-low reset.
//    - The matching read-side block reuses it.
// TESTING (ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=2, raddr_g=0 unless stated)
//  - Reset: hold wrst=0 with winc=1.
//    - Expect waddress=0, waddr_g=0, wfull=0, wafull=0, wfree=8, woverflow=0 throughout.
//  - Fill: 8 consecutive winc.
//    - waddr_g sequence: 1,3,2,6,7,5,4,12.
//    - wfull=1 on the 8th edge, with wfree=0.
//    - A 9th winc leaves waddr_g=12 and waddress=0, and sets woverflow=1.
//  - Drain visibility: from full, set raddr_g=3 (gray of 2).
//    - wfull falls exactly 3 edges later, with wfree=2.
//    - woverflow stays 1.
//  - Wrap: 16 writes interleaved with reads, wbin going 15->0 and waddr_g going 8->0.
//    - With raddr_g=12 (gray of 8) and wbin=0, expect wfull=1.
//  - Almost-full:
//    - Macro defined: wafull=1 from the 6th write edge (wfree=2); it drops when wfree returns to 3.
//    - Macro undefined: wafull=0 throughout.
//  - Reset mid-operation: pull wrst low asynchronously after 5 writes.
//    - All outputs and sync stages take reset values before the next wclk edge.
//    - After release, the first write is to waddress=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared pointer helpers and default geometry for the async FIFO
//               write-side and read-side pointer engines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  // Default geometry; the pointer engines carry their own ADDR_WIDTH parameter
  localparam int ADDR_WIDTH_DFLT = 3;
  localparam int DEPTH           = 2 ** ADDR_WIDTH_DFLT;
  localparam int PTR_WIDTH       = ADDR_WIDTH_DFLT + 1;

  // Binary to Gray; callers zero-extend in and truncate out, so any width up to 32 works
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary as an XOR prefix from the MSB down; zero upper bits leave the result intact
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_sync.sv
// ============================================================================
// Module      : gray_sync
// Description : SYNC_STAGES-deep flop chain carrying a Gray-coded pointer into
//               the local clock domain. Shared by both FIFO pointer engines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Fewer than two stages gives no metastability settling time
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("gray_sync: SYNC_STAGES must be at least 2");
  end

  logic [WIDTH-1:0] r_q [SYNC_STAGES];

  // Shift the asynchronous pointer through the chain; every stage resets to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_q[i] <= r_q[i-1];
      end
    end
  end

  assign q = r_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fifo_wptr_sync.sv
// ============================================================================
// Module      : fifo_wptr_sync
// Description : Write-side pointer and flag engine of the async FIFO. Holds the
//               binary/Gray write pointer, synchronises the read Gray pointer and
//               produces registered full, almost-full, free-space and sticky
//               overflow flags.
// Options     : FIFO_WPTR_AFULL_EN - build the almost-full comparator; when
//               undefined wafull is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wptr_sync
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DFLT,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   raddr_g,
  output logic [ADDR_WIDTH-1:0] waddress,
  output logic [ADDR_WIDTH:0]   waddr_g,
  output logic                  wfull,
  output logic                  wafull,
  output logic [ADDR_WIDTH:0]   wfree,
  output logic                  woverflow
);

  localparam int PW      = ADDR_WIDTH + 1;
  localparam int DEPTH_N = 2 ** ADDR_WIDTH;

  // The threshold only makes sense strictly inside the FIFO depth
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH_N - 1) begin : g_bad_thresh
    $error("fifo_wptr_sync: AFULL_THRESH out of range");
  end

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] rq_last;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] used_next;
  logic [PW-1:0] free_next;
  logic          wr_en;

  gray_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst),
    .d     (raddr_g),
    .q     (rq_last)
  );

  // Next-state pointer and occupancy; the stale read pointer can only over-count used entries
  assign wr_en     = winc & ~wfull;
  assign wbin_next = wbin + PW'(wr_en);
  assign rbin_s    = PW'(gray2bin(32'(rq_last)));
  assign used_next = wbin_next - rbin_s;
  assign free_next = PW'(DEPTH_N) - used_next;
  assign waddress  = wbin[ADDR_WIDTH-1:0];

  // Pointer registers and flags, all loaded from next-state values so accepted writes show at once
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin      <= '0;
      waddr_g   <= '0;
      wfull     <= 1'b0;
      wfree     <= PW'(DEPTH_N);
      woverflow <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      waddr_g <= PW'(bin2gray(32'(wbin_next)));
      wfull   <= (used_next == PW'(DEPTH_N));
      wfree   <= free_next;
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_WPTR_AFULL_EN
  // Almost-full once the free count falls to the threshold
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wafull <= 1'b0;
    end else begin
      wafull <= (free_next <= PW'(AFULL_THRESH));
    end
  end
`else
  assign wafull = 1'b0;
`endif

endmodule

`default_nettype wire
